// File: rtl/usb_pkg.sv
// Shared sizing constants and AHB access-size encoding for the USB data buffer.
package usb_pkg;

  localparam int unsigned BUF_DEPTH = 64;
  localparam int unsigned PTR_W     = 6;
  localparam int unsigned OCC_W     = 7;
  localparam int unsigned MAX_LANES = 4;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_3B = 2'd2,
    SZ_4B = 2'd3
  } size_t;

  function automatic logic [2:0] size_lanes(input size_t sz);
    return {1'b0, sz} + 3'd1;
  endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// Byte-wide register array with multi-lane write and combinational read ports.
module usb_buffer_mem
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH,
  parameter int unsigned LANES = MAX_LANES,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [LANES-1:0]    wr_en,
  input  logic [LANES*AW-1:0] wr_addr,
  input  logic [LANES*8-1:0]  wr_data,
  input  logic [LANES*AW-1:0] rd_addr,
  output logic [LANES*8-1:0]  rd_data,
  input  logic [AW-1:0]       head_addr,
  output logic [7:0]          head_data
);

  logic [7:0] mem [DEPTH];

  // Lanes always target distinct addresses, so per-lane writes never collide.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wr_en[k]) mem[wr_addr[k*AW +: AW]] <= wr_data[k*8 +: 8];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_data[k*8 +: 8] = mem[rd_addr[k*AW +: AW]];
    end
  end

  assign head_data = mem[head_addr];

endmodule

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO between USB RX/TX and the AHB slave: pointers, occupancy,
// request arbitration and the registered AHB read word.
module usb_data_buffer #(
  parameter int unsigned DEPTH     = usb_pkg::BUF_DEPTH,
  parameter int unsigned MAX_LANES = usb_pkg::MAX_LANES
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    flush,
  input  logic                    clear,
  input  logic                    store_rx_packet_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    get_rx_data,
  input  logic                    store_tx_data,
  input  logic [1:0]              data_size,
  input  logic [31:0]             tx_data,
  output logic [31:0]             rx_data,
  input  logic                    get_tx_packet_data,
  output logic [7:0]              tx_packet_data,
  output logic [$clog2(DEPTH):0]  buffer_occupancy
);
  import usb_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned CW = 3;

  logic [AW-1:0]           rd_ptr, wr_ptr;
  logic [OW-1:0]           occ, free;
  logic [CW-1:0]           n_lanes, wr_cnt, rd_cnt;
  logic                    kill;
  size_t                   sz;

  logic [MAX_LANES-1:0]    wr_en;
  logic [MAX_LANES*AW-1:0] wr_addr, rd_addr;
  logic [MAX_LANES*8-1:0]  wr_data, rd_data;
  logic [31:0]             rx_next;
  logic [7:0]              head_data;

  assign sz      = size_t'(data_size);
  assign n_lanes = size_lanes(sz);
  assign kill    = flush | clear;
  assign free    = OW'(DEPTH) - occ;

  // Counts come from the current occupancy only, so a same-cycle read never
  // frees room for a write and a same-cycle write never feeds a read.
  always_comb begin
    wr_cnt = '0;
    rd_cnt = '0;
    if (!kill) begin
      if (store_rx_packet_data)
        wr_cnt = (occ < OW'(DEPTH)) ? CW'(1) : CW'(0);
      else if (store_tx_data)
        wr_cnt = (OW'(n_lanes) <= free) ? n_lanes : CW'(free);
      if (get_rx_data)
        rd_cnt = (OW'(n_lanes) <= occ) ? n_lanes : CW'(occ);
      else if (get_tx_packet_data)
        rd_cnt = (occ != '0) ? CW'(1) : CW'(0);
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    rx_next = '0;
    for (int unsigned k = 0; k < MAX_LANES; k++) begin
      wr_en[k]             = CW'(k) < wr_cnt;
      wr_addr[k*AW +: AW]  = wr_ptr + AW'(k);
      wr_data[k*8 +: 8]    = store_rx_packet_data ? rx_packet_data : tx_data[k*8 +: 8];
      rd_addr[k*AW +: AW]  = rd_ptr + AW'(k);
      rx_next[k*8 +: 8]    = (CW'(k) < rd_cnt) ? rd_data[k*8 +: 8] : 8'h00;
    end
  end

  usb_buffer_mem #(
    .DEPTH (DEPTH),
    .LANES (MAX_LANES),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .head_addr (rd_ptr),
    .head_data (head_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      rx_data <= '0;
    end else if (kill) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(rd_cnt);
      occ    <= occ + OW'(wr_cnt) - OW'(rd_cnt);
      if (get_rx_data) rx_data <= rx_next;
    end
  end

  assign buffer_occupancy = occ;
  assign tx_packet_data   = (occ != '0) ? head_data : 8'h00;

endmodule
